// File: rtl/inc_arb_pkg.sv
// Shared types and constants for the round-robin counter-increment scheduler.
// Overflow modes select between wrapping and saturating counters.
package inc_arb_pkg;

  localparam int OVF_WRAP = 0;
  localparam int OVF_SAT  = 1;

  // Requester index type for the default four-requester configuration;
  // instances with other N size their index locally from $clog2(N).
  localparam int DEF_N = 4;
  typedef logic [$clog2(DEF_N)-1:0] id_t;

endpackage

// File: rtl/inc.sv
// Single W-bit incrementer with carry-out, shared by all counters.
// Purely combinational, zero latency, no flow control.
module inc #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o,
  output logic         co_o
);

  assign {co_o, y_o} = {1'b0, a_i} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/rr_arb.sv
// N-way round-robin arbiter: searches upward from ptr (mod N) for the first request.
// Purely combinational, zero latency; the pointer is owned by the caller.
module rr_arb #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld
);

  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inc_arb.sv
// Round-robin scheduler sharing one incrementer among N private counters.
// Grant is combinational, response registered one cycle later; no back-pressure.
module inc_arb
  import inc_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int SAT = OVF_WRAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         clr_i,
  output logic [N-1:0]         gnt_o,
  output logic                 rsp_vld_o,
  output logic [$clog2(N)-1:0] rsp_id_o,
  output logic [W-1:0]         rsp_cnt_o,
  output logic                 rsp_ovf_o,
  input  logic [$clog2(N)-1:0] rd_id_i,
  output logic [W-1:0]         rd_cnt_o
);

  localparam int IDW = $clog2(N);

  logic [W-1:0]   cnt_q [N];
  logic [W-1:0]   cnt_d [N];
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_vld_q, rsp_vld_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic           rsp_ovf_q, rsp_ovf_d;

  logic [N-1:0]   elig;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic [W-1:0]   inc_a, inc_y, wr_val;
  logic           inc_co;

  // A clear wins over an increment for the same index; reset suppresses all grants.
  assign elig = rst ? '0 : (req_i & ~clr_i);

  rr_arb #(.N(N), .IDW(IDW)) u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  assign gnt_o = gnt;
  assign inc_a = cnt_q[gnt_id];

  inc #(.W(W)) u_inc (
    .a_i  (inc_a),
    .y_o  (inc_y),
    .co_o (inc_co)
  );

  assign wr_val = (SAT == OVF_SAT && inc_co) ? {W{1'b1}} : inc_y;

  always_comb begin
    ptr_d     = ptr_q;
    rsp_vld_d = 1'b0;
    rsp_id_d  = rsp_id_q;
    rsp_cnt_d = rsp_cnt_q;
    rsp_ovf_d = rsp_ovf_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = clr_i[i] ? '0 : cnt_q[i];
    end
    if (gnt_vld) begin
      cnt_d[gnt_id] = wr_val;
      ptr_d         = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
      rsp_vld_d     = 1'b1;
      rsp_id_d      = gnt_id;
      rsp_cnt_d     = wr_val;
      rsp_ovf_d     = inc_co;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      ptr_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_cnt_q <= '0;
      rsp_ovf_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_cnt_q <= rsp_cnt_d;
      rsp_ovf_q <= rsp_ovf_d;
    end
  end

  assign rsp_vld_o = rsp_vld_q;
  assign rsp_id_o  = rsp_id_q;
  assign rsp_cnt_o = rsp_cnt_q;
  assign rsp_ovf_o = rsp_ovf_q;
  assign rd_cnt_o  = cnt_q[rd_id_i];

endmodule

// File: tb/tb_inc_arb.sv
// Directed bench for inc_arb: a wrapping instance and a saturating instance share stimulus.
module tb_inc_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i, clr_i;
  logic [1:0] rd_id_i;

  logic [3:0] gnt_o,     s_gnt_o;
  logic       rsp_vld_o, s_rsp_vld_o;
  logic [1:0] rsp_id_o,  s_rsp_id_o;
  logic [7:0] rsp_cnt_o, s_rsp_cnt_o;
  logic       rsp_ovf_o, s_rsp_ovf_o;
  logic [7:0] rd_cnt_o,  s_rd_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inc_arb #(.N(4), .W(8), .SAT(0)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .clr_i(clr_i), .gnt_o(gnt_o),
    .rsp_vld_o(rsp_vld_o), .rsp_id_o(rsp_id_o), .rsp_cnt_o(rsp_cnt_o),
    .rsp_ovf_o(rsp_ovf_o), .rd_id_i(rd_id_i), .rd_cnt_o(rd_cnt_o)
  );

  inc_arb #(.N(4), .W(8), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .req_i(req_i), .clr_i(clr_i), .gnt_o(s_gnt_o),
    .rsp_vld_o(s_rsp_vld_o), .rsp_id_o(s_rsp_id_o), .rsp_cnt_o(s_rsp_cnt_o),
    .rsp_ovf_o(s_rsp_ovf_o), .rd_id_i(rd_id_i), .rd_cnt_o(s_rd_cnt_o)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_i = '0; clr_i = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 4'b1111; clr_i = '0; rd_id_i = '0;
    tick(); tick();
    #1;
    checks++;
    if (gnt_o !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt_o);
    end
    checks++;
    if (rsp_vld_o !== 1'b0 || rsp_id_o !== 2'd0 || rsp_cnt_o !== 8'd0 || rsp_ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got vld=%b id=%0d cnt=%0d ovf=%b expected all 0",
               rsp_vld_o, rsp_id_o, rsp_cnt_o, rsp_ovf_o);
    end
    for (int i = 0; i < 4; i++) begin
      rd_id_i = 2'(i); #1;
      checks++;
      if (rd_cnt_o !== 8'd0) begin
        errors++; $display("FAIL reset_cnt%0d: got %0d expected 0", i, rd_cnt_o);
      end
    end
    rst = 1'b0; req_i = '0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      req_i = 4'b1111; #1;
      exp_gnt = 4'b0001 << (k % 4);
      checks++;
      if (gnt_o !== exp_gnt) begin
        errors++; $display("FAIL fair_gnt%0d: got %b expected %b", k, gnt_o, exp_gnt);
      end
      tick();
      checks++;
      if (rsp_vld_o !== 1'b1 || rsp_id_o !== 2'(k % 4) || rsp_cnt_o !== 8'(k / 4 + 1)) begin
        errors++;
        $display("FAIL fair_rsp%0d: got vld=%b id=%0d cnt=%0d expected vld=1 id=%0d cnt=%0d",
                 k, rsp_vld_o, rsp_id_o, rsp_cnt_o, k % 4, k / 4 + 1);
      end
    end
    req_i = '0;
    for (int i = 0; i < 4; i++) begin
      rd_id_i = 2'(i); #1;
      checks++;
      if (rd_cnt_o !== 8'd2) begin
        errors++; $display("FAIL fair_cnt%0d: got %0d expected 2", i, rd_cnt_o);
      end
    end
    tick();
    checks++;
    if (rsp_vld_o !== 1'b0) begin
      errors++; $display("FAIL fair_idle_vld: got %b expected 0", rsp_vld_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_i = 4'b0100;
    for (int i = 1; i <= 256; i++) begin
      tick();
      checks++;
      if (rsp_vld_o !== 1'b1 || rsp_id_o !== 2'd2 || rsp_cnt_o !== 8'(i % 256) ||
          rsp_ovf_o !== (i == 256)) begin
        errors++;
        $display("FAIL wrap_rsp%0d: got vld=%b id=%0d cnt=%0d ovf=%b expected vld=1 id=2 cnt=%0d ovf=%0d",
                 i, rsp_vld_o, rsp_id_o, rsp_cnt_o, rsp_ovf_o, i % 256, (i == 256));
      end
    end
    req_i = '0;
  endtask

  task automatic test_saturate();
    do_reset();
    req_i = 4'b0100;
    for (int i = 1; i <= 257; i++) begin
      tick();
      checks++;
      if (s_rsp_vld_o !== 1'b1 || s_rsp_cnt_o !== 8'((i > 255) ? 255 : i) ||
          s_rsp_ovf_o !== (i >= 256)) begin
        errors++;
        $display("FAIL sat_rsp%0d: got vld=%b cnt=%0d ovf=%b expected vld=1 cnt=%0d ovf=%0d",
                 i, s_rsp_vld_o, s_rsp_cnt_o, s_rsp_ovf_o, (i > 255) ? 255 : i, (i >= 256));
      end
    end
    req_i = '0;
    rd_id_i = 2'd2; #1;
    checks++;
    if (s_rd_cnt_o !== 8'hFF) begin
      errors++; $display("FAIL sat_hold: got %0d expected 255", s_rd_cnt_o);
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    req_i = 4'b0010;
    for (int i = 0; i < 5; i++) tick();
    req_i = '0;
    rd_id_i = 2'd1; #1;
    checks++;
    if (rd_cnt_o !== 8'd5) begin
      errors++; $display("FAIL clr_pre: got %0d expected 5", rd_cnt_o);
    end
    req_i = 4'b1010; clr_i = 4'b0010; #1;
    checks++;
    if (gnt_o !== 4'b1000) begin
      errors++; $display("FAIL clr_gnt: got %b expected 1000", gnt_o);
    end
    tick();
    req_i = '0; clr_i = '0; #1;
    checks++;
    if (rsp_vld_o !== 1'b1 || rsp_id_o !== 2'd3 || rsp_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL clr_rsp: got vld=%b id=%0d cnt=%0d expected vld=1 id=3 cnt=1",
               rsp_vld_o, rsp_id_o, rsp_cnt_o);
    end
    rd_id_i = 2'd1; #1;
    checks++;
    if (rd_cnt_o !== 8'd0) begin
      errors++; $display("FAIL clr_cnt1: got %0d expected 0", rd_cnt_o);
    end
    rd_id_i = 2'd3; #1;
    checks++;
    if (rd_cnt_o !== 8'd1) begin
      errors++; $display("FAIL clr_cnt3: got %0d expected 1", rd_cnt_o);
    end
  endtask

  task automatic test_ptr_skip();
    do_reset();
    req_i = 4'b0001;
    tick();
    req_i = 4'b1001; #1;
    checks++;
    if (gnt_o !== 4'b1000) begin
      errors++; $display("FAIL skip_gnt3: got %b expected 1000", gnt_o);
    end
    tick();
    checks++;
    if (rsp_id_o !== 2'd3 || rsp_vld_o !== 1'b1) begin
      errors++; $display("FAIL skip_rsp3: got vld=%b id=%0d expected vld=1 id=3", rsp_vld_o, rsp_id_o);
    end
    #1;
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++; $display("FAIL skip_gnt0: got %b expected 0001", gnt_o);
    end
    tick();
    checks++;
    if (rsp_id_o !== 2'd0 || rsp_cnt_o !== 8'd2) begin
      errors++; $display("FAIL skip_rsp0: got id=%0d cnt=%0d expected id=0 cnt=2", rsp_id_o, rsp_cnt_o);
    end
    req_i = '0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    req_i = 4'b0110;
    tick();
    rst = 1'b1; #1;
    checks++;
    if (gnt_o !== 4'b0000) begin
      errors++; $display("FAIL mid_gnt_rst: got %b expected 0000", gnt_o);
    end
    tick();
    checks++;
    if (rsp_vld_o !== 1'b0) begin
      errors++; $display("FAIL mid_vld: got %b expected 0", rsp_vld_o);
    end
    for (int i = 0; i < 4; i++) begin
      rd_id_i = 2'(i); #1;
      checks++;
      if (rd_cnt_o !== 8'd0) begin
        errors++; $display("FAIL mid_cnt%0d: got %0d expected 0", i, rd_cnt_o);
      end
    end
    rst = 1'b0; #1;
    checks++;
    if (gnt_o !== 4'b0010) begin
      errors++; $display("FAIL mid_first_gnt: got %b expected 0010", gnt_o);
    end
    tick();
    req_i = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_wrap();
    test_saturate();
    test_clear_priority();
    test_ptr_skip();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inc_arb.md
# inc_arb

Round-robin scheduler that shares one W-bit `inc` incrementer among N requesters, each owning a private W-bit counter. At most one requester is granted per cycle. The granted counter is read, incremented and written back in that cycle. A registered response reports the new value and the carry-out one cycle later. It sits between event sources (per-port statistics, credit or sequence-number generators) and any consumer of the counts.

## Interface
Parameters:
- `N`, default 4: number of requesters and counters, N ≥ 2.
- `W`, default 8: counter width.
- `SAT`, default 0: overflow behaviour. 0 wraps to zero; 1 saturates at all-ones.

Ports (name, direction, width, meaning):
- `clk` input 1: sole clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_i` input N: per-requester increment request, level-sensitive.
- `clr_i` input N: per-requester counter clear.
- `gnt_o` output N: one-hot grant, combinational from `req_i`, `clr_i` and the priority pointer.
- `rsp_vld_o` output 1: response valid, registered.
- `rsp_id_o` output $clog2(N): index of the responding requester.
- `rsp_cnt_o` output W: counter value after the increment.
- `rsp_ovf_o` output 1: incrementer carry-out; an increment was attempted at all-ones.
- `rd_id_i` input $clog2(N): read-port index.
- `rd_cnt_o` output W: combinational read of counter `rd_id_i`; shows the pre-edge value.

## Operation
Eligibility and arbitration:
- The eligible set is `req_i & ~clr_i`. A clear always beats an increment for the same index in the same cycle; that requester is not granted.
- Round-robin arbitration over the eligible set. Priority starts at pointer `ptr` and searches upward modulo N.
- When a grant occurs, `ptr` becomes (granted index + 1) mod N; this wraps from N-1 to 0. With no grant, `ptr` holds.

Counter update:
- The granted counter is fed through the single `inc` instance: `{carry, y} = cnt + 1`.
- SAT=0: counter ← y, so all-ones wraps to 0.
- SAT=1: counter ← carry ? all-ones : y.
- Clears and the increment write in the same edge. Any number of `clr_i` bits may be set together; every non-granted cleared counter goes to 0.

Response:
- On a grant, the response registers load vld=1, id=granted index, cnt=written value and ovf=carry.
- With no grant, vld=0 and id/cnt/ovf hold their previous values.
- There is no back-pressure: a consumer must accept every response.
- A requester holding `req_i` high is re-granted when its turn returns. Each cycle it is granted counts as exactly one increment.

## Timing
- Grant: same cycle as `req_i`, combinational.
- Counter update: at the edge that ends the grant cycle.
- Response latency: 1 cycle. The response appears the cycle after the grant.
- Same requester granted back-to-back (only possible when it is the sole eligible requester): the second increment sees the first result, with no hazard bubble.
- Throughput: 1 increment per cycle.

Reset (`rst`=1 at an edge):
- All counters → 0, `ptr` → 0.
- `rsp_vld_o` → 0, `rsp_id_o` → 0, `rsp_cnt_o` → 0, `rsp_ovf_o` → 0.
- `gnt_o` is forced to 0 while `rst` is high.
- Reset mid-stream discards any in-flight response. No increment is applied on a reset edge.

## Structure
- Package `inc_arb_pkg`:
  - `id_t` typedef, width $clog2(N) (made a module-level localparam if N varies per instance).
  - Constants `OVF_WRAP`=0 and `OVF_SAT`=1.
- Sub-module `rr_arb`: N-way round-robin arbiter.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt`, encoded `gnt_id`, `gnt_vld`.
  - Purely combinational, with `ptr` kept in `inc_arb`. Reusable elsewhere.
- Existing `inc` module is instantiated once, with W matching the counter width.
- Counters are held in a flop array of N×W bits; the read port is a mux on `rd_id_i`.

## Test plan
- Fairness, N=4: after reset, hold `req_i`=4'b1111 for 8 cycles. Required: `gnt_o` sequence 0001,0010,0100,1000 repeating; each counter reads 2; `rsp_id_o` lags grants by 1 cycle.
- Wrap, W=8, SAT=0: requester 2 alone requests 256 times. Required: the 255th response has cnt=255, ovf=0; the 256th has cnt=0, ovf=1.
- Saturate, SAT=1: same stimulus as the wrap test, plus one more request. Required: the 256th and 257th responses both have cnt=255, ovf=1.
- Clear priority: counter 1 at 5; assert `req_i[1]` and `clr_i[1]` together. Required: `gnt_o[1]`=0, no response for id 1, counter 1 reads 0 the next cycle. Also check that a concurrently requesting requester 3 is granted.
- Pointer skip: `ptr`=1 with `req_i`=4'b1001. Required: grant index 3, `ptr` becomes 0. Next cycle, same requests: grant index 0.
- Reset mid-stream: assert `rst` the cycle after a grant. Required: `rsp_vld_o`=0 next cycle, all counters 0, and the first grant after reset goes to the lowest requesting index.
